// File: rtl/leg_phase_responder.sv
// leg_phase_responder
//   Responder end of the three-phase gait handshake. Times each gait phase,
//   drives the lift/swing actuator enables and returns per-phase ready
//   signals to the gait sequencer. One instance per leg.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   en       in   timer enable; low pauses the timer and gates rdy* low
//   ack0     in   sequencer phase-0 accept strobe
//   ack1     in   sequencer phase-1 accept strobe
//   act2     in   sequencer phase-2 active level
//   err_clr  in   synchronous clear of err
//   rdy0     out  phase 0 may complete
//   rdy1     out  phase 1 may complete
//   rdy2     out  phase 2 may complete
//   lift     out  lift actuator enable
//   swing    out  swing actuator enable
//   phase    out  current phase (0, 1 or 2)
//   err      out  sticky protocol error
module leg_phase_responder #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned T0    = 100,
  parameter int unsigned T1    = 200,
  parameter int unsigned T2    = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ack0,
  input  logic       ack1,
  input  logic       act2,
  input  logic       err_clr,
  output logic       rdy0,
  output logic       rdy1,
  output logic       rdy2,
  output logic       lift,
  output logic       swing,
  output logic [1:0] phase,
  output logic       err
);

  // Terminal timer values; a duration of 0 behaves as 1.
  localparam logic [CNT_W-1:0] L0 = (T0 == 0) ? '0 : CNT_W'(T0 - 1);
  localparam logic [CNT_W-1:0] L1 = (T1 == 0) ? '0 : CNT_W'(T1 - 1);
  localparam logic [CNT_W-1:0] L2 = (T2 == 0) ? '0 : CNT_W'(T2 - 1);

  typedef enum logic [2:0] {
    S_SETTLE,
    S_RDY0,
    S_LIFT,
    S_RDY1,
    S_SWING,
    S_RDY2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_last;
  logic             w_timed;
  logic             w_done;
  logic             w_err_set;
  logic [1:0]       w_phase;

  always_comb begin
    w_last  = '0;
    w_timed = 1'b0;
    case (r_state)
      S_SETTLE: begin w_last = L0; w_timed = 1'b1; end
      S_LIFT:   begin w_last = L1; w_timed = 1'b1; end
      S_SWING:  begin w_last = L2; w_timed = 1'b1; end
      default:  begin w_last = '0; w_timed = 1'b0; end
    endcase
    w_done = w_timed && en && (r_timer == w_last);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_SETTLE: if (w_done) w_next = S_RDY0;
      S_RDY0:   if (ack0 && en) w_next = S_LIFT;
      S_LIFT:   if (w_done) w_next = S_RDY1;
      S_RDY1:   if (ack1 && en) w_next = S_SWING;
      // Loss of act2 takes priority over timer expiry.
      S_SWING:  if (!act2) w_next = S_SETTLE;
                else if (w_done) w_next = S_RDY2;
      S_RDY2:   if (!act2) w_next = S_SETTLE;
      default:  w_next = S_SETTLE;
    endcase
  end

  always_comb begin
    w_err_set = (ack0 && (r_state != S_RDY0)) ||
                (ack1 && (r_state != S_RDY1)) ||
                (act2 && ((r_state == S_SETTLE) || (r_state == S_RDY0) ||
                          (r_state == S_LIFT)   || (r_state == S_RDY1))) ||
                (!act2 && (r_state == S_SWING));
  end

  always_comb begin
    case (w_next)
      S_LIFT, S_RDY1:  w_phase = 2'd1;
      S_SWING, S_RDY2: w_phase = 2'd2;
      default:         w_phase = 2'd0;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same
  // edge as the state register, with no input-to-output combinational path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_SETTLE;
      r_timer <= '0;
      rdy0    <= 1'b0;
      rdy1    <= 1'b0;
      rdy2    <= 1'b0;
      lift    <= 1'b0;
      swing   <= 1'b0;
      phase   <= 2'd0;
      err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_timer <= '0;
      else if (w_timed && en)
        r_timer <= r_timer + CNT_W'(1);
      rdy0  <= (w_next == S_RDY0) && en;
      rdy1  <= (w_next == S_RDY1) && en;
      rdy2  <= (w_next == S_RDY2) && en;
      lift  <= (w_next == S_LIFT)  || (w_next == S_RDY1);
      swing <= (w_next == S_SWING) || (w_next == S_RDY2);
      phase <= w_phase;
      if (w_err_set)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_leg_phase_responder.sv
module tb_leg_phase_responder;

  localparam int T0 = 4;
  localparam int T1 = 6;
  localparam int T2 = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       ack0 = 1'b0;
  logic       ack1 = 1'b0;
  logic       act2 = 1'b0;
  logic       err_clr = 1'b0;
  logic       rdy0, rdy1, rdy2, lift, swing, err;
  logic [1:0] phase;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mark  = 0;
  int lat;

  leg_phase_responder #(.CNT_W(16), .T0(T0), .T1(T1), .T2(T2)) dut (
    .clk(clk), .rst(rst), .en(en), .ack0(ack0), .ack1(ack1), .act2(act2),
    .err_clr(err_clr), .rdy0(rdy0), .rdy1(rdy1), .rdy2(rdy2), .lift(lift),
    .swing(swing), .phase(phase), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: gait position 0..5 in order SETTLE, RDY0, LIFT,
  // RDY1, SWING, RDY2; m_el counts enabled cycles spent in a timed position.
  int m_st  = 0;
  int m_el  = 0;
  bit m_err = 1'b0;
  bit m_en  = 1'b0;

  function automatic int dur(input int s);
    int t;
    t = (s == 0) ? T0 : (s == 2) ? T1 : T2;
    return (t == 0) ? 1 : t;
  endfunction

  always @(posedge clk or negedge rst) begin
    bit ev;
    if (!rst) begin
      m_st = 0; m_el = 0; m_err = 1'b0; m_en = 1'b0;
    end else begin
      ev = (ack0 && m_st != 1) || (ack1 && m_st != 3) ||
           (act2 && m_st < 4) || (m_st == 4 && !act2);
      if (m_st == 4 && !act2) begin
        m_st = 0; m_el = 0;
      end else if (m_st == 0 || m_st == 2 || m_st == 4) begin
        if (en) begin
          m_el++;
          if (m_el >= dur(m_st)) begin m_st++; m_el = 0; end
        end
      end else if (m_st == 1) begin
        if (ack0 && en) m_st = 2;
      end else if (m_st == 3) begin
        if (ack1 && en) m_st = 4;
      end else if (m_st == 5) begin
        if (!act2) m_st = 0;
      end
      if (ev) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      m_en = en;
    end
  end

  function automatic int model_vec();
    logic [7:0] v;
    v[7]   = (m_st == 1) && m_en;
    v[6]   = (m_st == 3) && m_en;
    v[5]   = (m_st == 5) && m_en;
    v[4]   = (m_st == 2) || (m_st == 3);
    v[3]   = (m_st >= 4);
    v[2:1] = 2'(m_st / 2);
    v[0]   = m_err;
    return int'(v);
  endfunction

  function automatic int dut_vec();
    return int'({rdy0, rdy1, rdy2, lift, swing, phase, err});
  endfunction

  always @(negedge clk) check("model_cmp", dut_vec(), model_vec());

  function automatic logic outsel(input int w);
    case (w)
      0:       return rdy0;
      1:       return rdy1;
      default: return rdy2;
    endcase
  endfunction

  // Bounded wait for a ready output; latency is in edges since 'mark'.
  task automatic wait_rdy(input int w, output int l);
    l = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (outsel(w)) begin
        l = cyc - mark;
        break;
      end
    end
  endtask

  task automatic pulse_ack0();
    ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    mark = cyc;
  endtask

  task automatic pulse_ack1_start_swing();
    ack1 = 1'b1;
    @(negedge clk);
    ack1 = 1'b0;
    act2 = 1'b1;
    mark = cyc;
  endtask

  initial begin
    // Reset release with en high
    repeat (3) @(negedge clk);
    rst = 1'b1;
    mark = cyc;
    wait_rdy(0, lat);
    check("rdy0_lat_reset", lat, 4);
    check("settle_outs", int'({lift, swing, phase, err}), 0);

    // en low gates rdy0 in RDY0
    en = 1'b0;
    @(negedge clk);
    check("rdy0_gated", int'(rdy0), 0);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("rdy0_regate", int'(rdy0), 1);

    // Full cycle
    pulse_ack0();
    check("lift_on", int'({lift, swing, phase}), 'b1001);
    wait_rdy(1, lat);
    check("rdy1_lat", lat, 6);
    pulse_ack1_start_swing();
    check("swing_on", int'({lift, swing, phase}), 'b0110);
    wait_rdy(2, lat);
    check("rdy2_lat", lat, 5);
    repeat (2) @(negedge clk);
    check("rdy2_held", int'({rdy2, swing}), 'b11);
    act2 = 1'b0;
    @(negedge clk);
    check("return_settle", int'({rdy2, swing, phase, err}), 0);
    mark = cyc;
    wait_rdy(0, lat);
    check("rdy0_lat_cycle", lat, 4);

    // en paused for 3 cycles mid-LIFT
    pulse_ack0();
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    wait_rdy(1, lat);
    check("rdy1_lat_paused", lat, 9);
    pulse_ack1_start_swing();
    wait_rdy(2, lat);
    check("rdy2_lat_2", lat, 5);
    act2 = 1'b0;
    @(negedge clk);
    mark = cyc;
    wait_rdy(0, lat);
    check("rdy0_lat_2", lat, 4);

    // ack1 during LIFT: error, state unchanged, then cleared
    pulse_ack0();
    repeat (2) @(negedge clk);
    ack1 = 1'b1;
    @(negedge clk);
    ack1 = 1'b0;
    check("ack1_in_lift", int'({err, lift, phase, rdy1}), 'b1_1_01_0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", int'(err), 0);
    wait_rdy(1, lat);
    check("rdy1_lat_3", lat, 6);

    // act2 dropped on the second SWING cycle aborts to SETTLE
    pulse_ack1_start_swing();
    @(negedge clk);
    act2 = 1'b0;
    @(negedge clk);
    mark = cyc;
    check("swing_abort", int'({swing, phase, err}), 'b0_00_1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared_2", int'(err), 0);
    wait_rdy(0, lat);
    check("rdy0_lat_abort", lat, 4);

    // act2 seen in RDY0: error, rdy0 kept
    act2 = 1'b1;
    @(negedge clk);
    act2 = 1'b0;
    check("act2_in_rdy0", int'({err, rdy0}), 'b11);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // Asynchronous reset while in RDY1
    pulse_ack0();
    wait_rdy(1, lat);
    check("rdy1_lat_4", lat, 6);
    #2 rst = 1'b0;
    #1 check("async_reset", int'({lift, rdy1, phase}), 0);
    @(negedge clk);
    rst = 1'b1;
    mark = cyc;
    wait_rdy(0, lat);
    check("rdy0_after_rst", lat, 4);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
